// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// 16-bit integer ALU for the CR16-style datapath. Decodes oper/func, produces
// the result, the new PSR flags {C,L,F,Z,N} and a per-flag write enable for
// the external PSR register. The result feeds register-file writeback and the
// PC mux (BCOND / JCOND targets).
//
// Configuration macro: ALU_OUTPUT_REG_EN
//   undefined : outputs are purely combinational, clk/reset are ignored.
//   defined   : result/condOut/condWr are registered on posedge clk
//               (1-cycle latency); reset clears all three outputs.
//
// Ports
//   clk      in   1  clock (registered build only)
//   reset    in   1  synchronous active-high reset (registered build only)
//   dst      in  16  destination operand (Rdest, or PC for BCOND)
//   src      in  16  source operand (Rsrc / immediate / displacement)
//   oper     in   4  major opcode
//   func     in   4  sub-function for REG / SHIFT / SPECIAL
//   cond     in   4  condition select for BCOND / JCOND / SCOND
//   condIn   in   5  current PSR {C,L,F,Z,N}
//   condOut  out  5  new flags {C,L,F,Z,N}
//   condWr   out  5  per-flag write enables, same bit order
//   result   out 16  ALU result
// ---------------------------------------------------------------------------
module alu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dst,
    input  logic [15:0] src,
    input  logic [3:0]  oper,
    input  logic [3:0]  func,
    input  logic [3:0]  cond,
    input  logic [4:0]  condIn,
    output logic [4:0]  condOut,
    output logic [4:0]  condWr,
    output logic [15:0] result
);

    localparam int DATA_W = 16;

    // Major opcodes
    localparam logic [3:0] OP_REG     = 4'd0;
    localparam logic [3:0] OP_ANDI    = 4'd1;
    localparam logic [3:0] OP_ORI     = 4'd2;
    localparam logic [3:0] OP_XORI    = 4'd3;
    localparam logic [3:0] OP_SPECIAL = 4'd4;
    localparam logic [3:0] OP_ADDI    = 4'd5;
    localparam logic [3:0] OP_ADDUI   = 4'd6;
    localparam logic [3:0] OP_ADDCI   = 4'd7;
    localparam logic [3:0] OP_SHIFT   = 4'd8;
    localparam logic [3:0] OP_SUBI    = 4'd9;
    localparam logic [3:0] OP_SUBCI   = 4'd10;
    localparam logic [3:0] OP_CMPI    = 4'd11;
    localparam logic [3:0] OP_BCOND   = 4'd12;
    localparam logic [3:0] OP_MOVI    = 4'd13;
    localparam logic [3:0] OP_MULI    = 4'd14;
    localparam logic [3:0] OP_LUI     = 4'd15;

    // REG sub-functions
    localparam logic [3:0] F_AND  = 4'd1;
    localparam logic [3:0] F_OR   = 4'd2;
    localparam logic [3:0] F_XOR  = 4'd3;
    localparam logic [3:0] F_NOT  = 4'd4;
    localparam logic [3:0] F_ADD  = 4'd5;
    localparam logic [3:0] F_ADDU = 4'd6;
    localparam logic [3:0] F_ADDC = 4'd7;
    localparam logic [3:0] F_SUB  = 4'd9;
    localparam logic [3:0] F_SUBC = 4'd10;
    localparam logic [3:0] F_CMP  = 4'd11;
    localparam logic [3:0] F_MOV  = 4'd13;
    localparam logic [3:0] F_MUL  = 4'd14;
    localparam logic [3:0] F_TEST = 4'd15;

    // SHIFT sub-functions
    localparam logic [3:0] S_LSHI_L  = 4'd0;
    localparam logic [3:0] S_LSHI_R  = 4'd1;
    localparam logic [3:0] S_ASHUI_L = 4'd2;
    localparam logic [3:0] S_ASHUI_R = 4'd3;
    localparam logic [3:0] S_LSH     = 4'd4;
    localparam logic [3:0] S_ASHU    = 4'd6;

    // SPECIAL sub-functions
    localparam logic [3:0] X_JAL   = 4'd8;
    localparam logic [3:0] X_JCOND = 4'd12;
    localparam logic [3:0] X_SCOND = 4'd13;

    // Condition evaluation against PSR {c,l,f,z,n}
    function automatic logic cond_eval(input logic [3:0] sel, input logic [4:0] psr);
        logic c, l, f, z, n;
        {c, l, f, z, n} = psr;
        case (sel)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = !z;
            4'd2:    cond_eval = c;
            4'd3:    cond_eval = !c;
            4'd4:    cond_eval = l;
            4'd5:    cond_eval = !l;
            4'd6:    cond_eval = n;
            4'd7:    cond_eval = !n;
            4'd8:    cond_eval = f;
            4'd9:    cond_eval = !f;
            4'd10:   cond_eval = !l && !z;
            4'd11:   cond_eval = l || z;
            4'd12:   cond_eval = !n && !z;
            4'd13:   cond_eval = n || z;
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic                     is_reg;
    logic                     add_grp;
    logic                     sub_grp;
    logic                     cin;
    logic                     co;
    logic                     bo;
    logic [DATA_W-1:0]        sum;
    logic [DATA_W-1:0]        diff;
    logic [DATA_W-1:0]        mul_lo;
    logic [DATA_W-1:0]        shl;
    logic [DATA_W-1:0]        shr_log;
    logic [DATA_W-1:0]        shr_ari;
    logic [4:0]               sr_amt;
    logic signed [DATA_W-1:0] dst_s;
    logic signed [DATA_W-1:0] asr_raw;
    logic                     cond_true;

    logic [DATA_W-1:0]        result_p0;
    logic [4:0]               cond_out_p0;
    logic [4:0]               cond_wr_p0;

    // ---- stage p0: decode, arithmetic, result mux, flags ----
    always_comb begin
        is_reg  = (oper == OP_REG);
        add_grp = (oper == OP_ADDI) || (oper == OP_ADDUI) || (oper == OP_ADDCI) ||
                  (is_reg && ((func == F_ADD) || (func == F_ADDU) || (func == F_ADDC)));
        sub_grp = (oper == OP_SUBI) || (oper == OP_SUBCI) || (oper == OP_CMPI) ||
                  (is_reg && ((func == F_SUB) || (func == F_SUBC) || (func == F_CMP)));
        cin     = condIn[4] &&
                  ((oper == OP_ADDCI) || (oper == OP_SUBCI) ||
                   (is_reg && ((func == F_ADDC) || (func == F_SUBC))));
    end

    assign {co, sum}  = {1'b0, dst} + {1'b0, src} + {16'd0, cin};
    // bit 16 of the 17-bit difference is the borrow out
    assign {bo, diff} = {1'b0, dst} - {1'b0, src} - {16'd0, cin};
    assign mul_lo     = dst * src;

    // Right shifts are encoded as negative left-shift counts
    assign sr_amt  = 5'd0 - src[4:0];
    assign dst_s   = dst;
    assign asr_raw = dst_s >>> sr_amt[3:0];
    assign shl     = dst << src[3:0];
    assign shr_log = sr_amt[4] ? '0 : (dst >> sr_amt[3:0]);
    assign shr_ari = sr_amt[4] ? {DATA_W{dst[15]}} : asr_raw;

    assign cond_true = cond_eval(cond, condIn);

    always_comb begin
        result_p0 = sum;
        case (oper)
            OP_REG: begin
                case (func)
                    F_AND, F_TEST:          result_p0 = dst & src;
                    F_OR:                   result_p0 = dst | src;
                    F_XOR:                  result_p0 = dst ^ src;
                    F_NOT:                  result_p0 = ~dst;
                    F_SUB, F_SUBC, F_CMP:   result_p0 = diff;
                    F_MOV:                  result_p0 = src;
                    F_MUL:                  result_p0 = mul_lo;
                    default:                result_p0 = sum;
                endcase
            end
            OP_ANDI:                        result_p0 = dst & src;
            OP_ORI:                         result_p0 = dst | src;
            OP_XORI:                        result_p0 = dst ^ src;
            OP_SPECIAL: begin
                case (func)
                    X_JAL:                  result_p0 = src;
                    X_JCOND:                result_p0 = cond_true ? src : dst;
                    X_SCOND:                result_p0 = {15'd0, cond_true};
                    default:                result_p0 = sum;
                endcase
            end
            OP_SHIFT: begin
                case (func)
                    S_LSHI_L, S_ASHUI_L:    result_p0 = shl;
                    S_LSHI_R:               result_p0 = shr_log;
                    S_ASHUI_R:              result_p0 = shr_ari;
                    S_LSH:                  result_p0 = src[15] ? shr_log : shl;
                    S_ASHU:                 result_p0 = src[15] ? shr_ari : shl;
                    default:                result_p0 = sum;
                endcase
            end
            OP_SUBI, OP_SUBCI, OP_CMPI:     result_p0 = diff;
            // cin is always 0 here, so sum is the PC-relative target
            OP_BCOND:                       result_p0 = cond_true ? sum : dst;
            OP_MOVI:                        result_p0 = src;
            OP_MULI:                        result_p0 = mul_lo;
            OP_LUI:                         result_p0 = {src[7:0], dst[7:0]};
            default:                        result_p0 = sum;
        endcase
    end

    always_comb begin
        logic flag_c, flag_l, flag_f, flag_z, flag_n;
        logic cf_set, cmp_op, z_set;

        flag_c = (add_grp && co) || (sub_grp && bo);
        flag_l = (dst < src);
        flag_f = 1'b0;
        if (add_grp)
            flag_f = (dst[15] == src[15]) && (sum[15] != dst[15]);
        else if (sub_grp)
            flag_f = (dst[15] != src[15]) && (diff[15] != dst[15]);
        flag_z = (result_p0 == '0);
        flag_n = result_p0[15];
        cond_out_p0 = {flag_c, flag_l, flag_f, flag_z, flag_n};

        // Unsigned adds and compares do not touch C/F
        cf_set = (oper == OP_ADDI) || (oper == OP_ADDCI) ||
                 (oper == OP_SUBI) || (oper == OP_SUBCI) ||
                 (is_reg && ((func == F_ADD) || (func == F_ADDC) ||
                             (func == F_SUB) || (func == F_SUBC)));
        cmp_op = (oper == OP_CMPI) || (is_reg && (func == F_CMP));
        z_set  = (oper == OP_ANDI) || (oper == OP_ORI) || (oper == OP_XORI) ||
                 (oper == OP_ADDI) || (oper == OP_ADDCI) || (oper == OP_SUBI) ||
                 (oper == OP_SUBCI) || (oper == OP_CMPI) ||
                 (is_reg && ((func == F_AND) || (func == F_OR) || (func == F_XOR) ||
                             (func == F_NOT) || (func == F_ADD) || (func == F_ADDC) ||
                             (func == F_SUB) || (func == F_SUBC) || (func == F_CMP) ||
                             (func == F_TEST)));
        cond_wr_p0 = {cf_set, cmp_op, cf_set, z_set, cf_set || cmp_op};
    end

`ifdef ALU_OUTPUT_REG_EN
    // ---- stage p1: output register ----
    logic [DATA_W-1:0] result_p1;
    logic [4:0]        cond_out_p1;
    logic [4:0]        cond_wr_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_p1   <= '0;
            cond_out_p1 <= '0;
            cond_wr_p1  <= '0;
        end else begin
            result_p1   <= result_p0;
            cond_out_p1 <= cond_out_p0;
            cond_wr_p1  <= cond_wr_p0;
        end
    end

    assign result  = result_p1;
    assign condOut = cond_out_p1;
    assign condWr  = cond_wr_p1;
`else
    // clk/reset exist only for the registered build
    logic ctl_unused;
    assign ctl_unused = clk ^ reset;

    assign result  = result_p0;
    assign condOut = cond_out_p0;
    assign condWr  = cond_wr_p0;
`endif

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [15:0] dst;
    logic [15:0] src;
    logic [3:0]  oper;
    logic [3:0]  func;
    logic [3:0]  cond;
    logic [4:0]  condIn;
    logic [4:0]  condOut;
    logic [4:0]  condWr;
    logic [15:0] result;

    int checks;
    int failures;

    alu_core dut (
        .clk     (clk),
        .reset   (reset),
        .dst     (dst),
        .src     (src),
        .oper    (oper),
        .func    (func),
        .cond    (cond),
        .condIn  (condIn),
        .condOut (condOut),
        .condWr  (condWr),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Works for both builds: inputs are held across the edge, and outputs are
    // sampled 1 time unit after it.
    task automatic vec(input string tag,
                       input logic [3:0] o, input logic [3:0] f,
                       input logic [3:0] c, input logic [4:0] ci,
                       input logic [15:0] d, input logic [15:0] s,
                       input logic [15:0] e_res, input logic [4:0] e_flg,
                       input logic [4:0] e_wr);
        oper = o; func = f; cond = c; condIn = ci; dst = d; src = s;
        @(posedge clk);
        #1;
        checks++;
        assert (result === e_res) else begin
            failures++;
            $error("FAIL %s result got=%h exp=%h", tag, result, e_res);
        end
        checks++;
        assert (condOut === e_flg) else begin
            failures++;
            $error("FAIL %s condOut got=%b exp=%b", tag, condOut, e_flg);
        end
        checks++;
        assert (condWr === e_wr) else begin
            failures++;
            $error("FAIL %s condWr got=%b exp=%b", tag, condWr, e_wr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        dst = 16'h0; src = 16'h0; oper = 4'd0; func = 4'd0; cond = 4'd0; condIn = 5'b0;

`ifdef ALU_OUTPUT_REG_EN
        // Reset must win over live, nonzero input data
        reset = 1'b1;
        vec("reset", 4'd0, 4'd5, 4'd0, 5'b00000, 16'h7FFF, 16'h0001,
            16'h0000, 5'b00000, 5'b00000);
        reset = 1'b0;
        vec("reg_add_1p1", 4'd0, 4'd5, 4'd0, 5'b00000, 16'h0001, 16'h0001,
            16'h0002, 5'b00000, 5'b10111);
`endif

        //        tag            oper   func   cond   condIn     dst       src       result    {CLFZN}    condWr
        vec("reg_add_ovf",  4'd0,  4'd5,  4'd0,  5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 5'b10111);
        vec("reg_subc_brw", 4'd0,  4'd10, 4'd0,  5'b10000, 16'h0000, 16'h0000, 16'hFFFF, 5'b10001, 5'b10111);
        vec("cmpi_lt",      4'd11, 4'd0,  4'd0,  5'b00000, 16'h0003, 16'h0005, 16'hFFFE, 5'b11001, 5'b01011);
        vec("ashu_r1",      4'd8,  4'd6,  4'd0,  5'b00000, 16'h8000, 16'hFFFF, 16'hC000, 5'b01001, 5'b00000);
        vec("lsh_r1",       4'd8,  4'd4,  4'd0,  5'b00000, 16'h8000, 16'hFFFF, 16'h4000, 5'b01000, 5'b00000);
        vec("lshi_l15",     4'd8,  4'd0,  4'd0,  5'b00000, 16'h0001, 16'h000F, 16'h8000, 5'b01001, 5'b00000);
        vec("ashui_r16",    4'd8,  4'd3,  4'd0,  5'b00000, 16'h8000, 16'h0010, 16'hFFFF, 5'b00001, 5'b00000);
        vec("lshi_r1",      4'd8,  4'd1,  4'd0,  5'b00000, 16'h8000, 16'h001F, 16'h4000, 5'b00000, 5'b00000);
        vec("bcond_eq_t",   4'd12, 4'd0,  4'd0,  5'b00010, 16'h0100, 16'h0010, 16'h0110, 5'b00000, 5'b00000);
        vec("bcond_eq_f",   4'd12, 4'd0,  4'd0,  5'b00000, 16'h0100, 16'h0010, 16'h0100, 5'b00000, 5'b00000);
        vec("jcond_uc",     4'd4,  4'd12, 4'd14, 5'b00000, 16'h1111, 16'h2222, 16'h2222, 5'b01000, 5'b00000);
        vec("jcond_never",  4'd4,  4'd12, 4'd15, 5'b11111, 16'h1111, 16'h2222, 16'h1111, 5'b01000, 5'b00000);
        vec("scond_lt",     4'd4,  4'd13, 4'd12, 5'b00000, 16'h0000, 16'h0000, 16'h0001, 5'b00000, 5'b00000);
        vec("lui",          4'd15, 4'd0,  4'd0,  5'b00000, 16'h1234, 16'h00AB, 16'hAB34, 5'b00001, 5'b00000);
        vec("muli_wrap",    4'd14, 4'd0,  4'd0,  5'b00000, 16'h0100, 16'h0100, 16'h0000, 5'b00010, 5'b00000);
        vec("andi",         4'd1,  4'd0,  4'd0,  5'b00000, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 5'b00010);
        vec("reg_not",      4'd0,  4'd4,  4'd0,  5'b00000, 16'h00FF, 16'h0000, 16'hFF00, 5'b00001, 5'b00010);
        vec("addci_carry",  4'd7,  4'd0,  4'd0,  5'b10000, 16'hFFFF, 16'h0000, 16'h0000, 5'b10010, 5'b10111);
        vec("subi_ovf",     4'd9,  4'd0,  4'd0,  5'b00000, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 5'b10111);
        vec("reg_undef",    4'd0,  4'd0,  4'd0,  5'b10000, 16'h0002, 16'h0003, 16'h0005, 5'b01000, 5'b00000);
        vec("addui_carry",  4'd6,  4'd0,  4'd0,  5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 5'b00000);
        vec("reg_test",     4'd0,  4'd15, 4'd0,  5'b00000, 16'h00F0, 16'h0F00, 16'h0000, 5'b01010, 5'b00010);
        vec("jal",          4'd4,  4'd8,  4'd0,  5'b00000, 16'h0000, 16'hABCD, 16'hABCD, 5'b01001, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
